// File: rtl/ncc_corr_if.sv
// rtl/ncc_corr_if.sv - descriptor load, window column and score bundle for ncc_corr_array
//
// Purpose: groups the descriptor handshake, the window column handshake and the
//          score strobe of the correlation engine.
// Ports (master = upstream/consumer side, slave = ncc_corr_array):
//   desc_valid/desc_ready/desc_data : descriptor beats, LOAD_W lanes of PIX_W
//   win_valid/win_ready/win_col/win_last : window columns, ROWS rows of PIX_W
//   score_valid/score/score_col     : single-cycle signed score and its line index
interface ncc_corr_if #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int PIX_W  = 8,
    parameter int LOAD_W = 4
);
    localparam int ACC_W = 2 * PIX_W + 1 + $clog2(ROWS * COLS);

    logic                     desc_valid;
    logic                     desc_ready;
    logic [LOAD_W*PIX_W-1:0]  desc_data;
    logic                     win_valid;
    logic                     win_ready;
    logic [ROWS*PIX_W-1:0]    win_col;
    logic                     win_last;
    logic                     score_valid;
    logic signed [ACC_W-1:0]  score;
    logic [15:0]              score_col;

    modport master (
        output desc_valid, desc_data, win_valid, win_col, win_last,
        input  desc_ready, win_ready, score_valid, score, score_col
    );

    modport slave (
        input  desc_valid, desc_data, win_valid, win_col, win_last,
        output desc_ready, win_ready, score_valid, score, score_col
    );
endinterface

// File: rtl/ncc_corr_array.sv
// rtl/ncc_corr_array.sv - sliding-window zero-mean descriptor correlation engine
//
// Purpose: loads a ROWS x COLS signed descriptor, shifts window columns in and
//          emits sum(desc*win) for every full window through a 3-stage pipeline.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous abort back to IDLE (descriptor must be reloaded)
//   bus      : ncc_corr_if slave (descriptor, window and score signals)
module ncc_corr_array #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int PIX_W  = 8,
    parameter int LOAD_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    ncc_corr_if.slave bus
);
    localparam int ACC_W = 2 * PIX_W + 1 + $clog2(ROWS * COLS);
    localparam int N     = ROWS * COLS;
    localparam int P_W   = 2 * PIX_W + 1;
    localparam int NB    = N / LOAD_W;
    localparam int LCW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int FCW   = $clog2(COLS + 1);
    localparam logic [LCW-1:0] LAST_BEAT = LCW'(NB - 1);
    localparam logic [FCW-1:0] LAST_FILL = FCW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

    state_t                  state_q, state_d;
    logic [LCW-1:0]          load_cnt_q, load_cnt_d;
    logic [FCW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [15:0]             col_cnt_q, col_cnt_d;
    logic                    desc_ready_q, desc_ready_d;
    logic                    win_ready_q, win_ready_d;
    logic signed [PIX_W-1:0] desc_q [N];
    logic signed [PIX_W-1:0] desc_d [N];
    logic [PIX_W-1:0]        win_q [ROWS][COLS];
    logic [PIX_W-1:0]        win_d [ROWS][COLS];
    // Valid/index tags travel alongside the window, S1 and S2 registers.
    logic                    iss_q, iss_d, v1_q, v1_d, v2_q, v2_d, sv_q, sv_d;
    logic [15:0]             iss_col_q, iss_col_d, col1_q, col1_d, col2_q, col2_d;
    logic [15:0]             score_col_q, score_col_d;
    logic signed [P_W-1:0]   prod_q [N];
    logic signed [P_W-1:0]   prod_d [N];
    logic signed [ACC_W-1:0] row_q [ROWS];
    logic signed [ACC_W-1:0] row_d [ROWS];
    logic signed [ACC_W-1:0] score_q, score_d, tot_c;
    logic                    desc_acc, win_acc;

    assign bus.desc_ready  = desc_ready_q;
    assign bus.win_ready   = win_ready_q;
    assign bus.score_valid = sv_q;
    assign bus.score       = score_q;
    assign bus.score_col   = score_col_q;

    // Control: load sequencing, window shift, score issue and abort.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        fill_cnt_d = fill_cnt_q;
        col_cnt_d  = col_cnt_q;
        desc_d     = desc_q;
        win_d      = win_q;
        iss_d      = 1'b0;
        iss_col_d  = iss_col_q;
        desc_acc   = bus.desc_valid && desc_ready_q && !clear;
        win_acc    = bus.win_valid && win_ready_q && !clear;

        if (desc_acc) begin
            for (int k = 0; k < N; k++) begin
                if (LCW'(k / LOAD_W) == load_cnt_q) begin
                    desc_d[k] = bus.desc_data[(k % LOAD_W)*PIX_W +: PIX_W];
                end
            end
            if (load_cnt_q == LAST_BEAT) begin
                state_d    = FILL;
                load_cnt_d = '0;
                fill_cnt_d = '0;
                col_cnt_d  = '0;
            end else begin
                state_d    = LOAD;
                load_cnt_d = load_cnt_q + 1'b1;
            end
        end

        if (win_acc) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][COLS-1] = bus.win_col[r*PIX_W +: PIX_W];
            end
            if (state_q == RUN) begin
                iss_d = 1'b1;
            end else if (fill_cnt_q == LAST_FILL) begin
                iss_d   = 1'b1;
                state_d = RUN;
            end else begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
            if (iss_d) begin
                iss_col_d = col_cnt_q;
                col_cnt_d = (col_cnt_q == 16'hFFFF) ? col_cnt_q : col_cnt_q + 16'd1;
            end
            // Line boundary: the next column starts a fresh window fill.
            if (bus.win_last) begin
                state_d    = FILL;
                fill_cnt_d = '0;
                col_cnt_d  = '0;
            end
        end

        if (clear) begin
            state_d    = IDLE;
            load_cnt_d = '0;
            fill_cnt_d = '0;
            col_cnt_d  = '0;
            iss_d      = 1'b0;
        end

        desc_ready_d = (state_d == IDLE) || (state_d == LOAD);
        win_ready_d  = (state_d == FILL) || (state_d == RUN);
    end

    // Datapath: S1 products, S2 row sums, S3 total; valids killed by clear.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                prod_d[r*COLS+c] = P_W'(desc_q[r*COLS+c]) * $signed(P_W'({1'b0, win_q[r][c]}));
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < COLS; c++) begin
                row_d[r] = row_d[r] + ACC_W'(prod_q[r*COLS+c]);
            end
        end
        tot_c = '0;
        for (int r = 0; r < ROWS; r++) begin
            tot_c = tot_c + row_q[r];
        end
        v1_d        = iss_q && !clear;
        col1_d      = iss_col_q;
        v2_d        = v1_q && !clear;
        col2_d      = col1_q;
        sv_d        = v2_q && !clear;
        score_d     = v2_q ? tot_c : score_q;
        score_col_d = v2_q ? col2_q : score_col_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            load_cnt_q   <= '0;
            fill_cnt_q   <= '0;
            col_cnt_q    <= '0;
            desc_ready_q <= 1'b1;
            win_ready_q  <= 1'b0;
            iss_q        <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            sv_q         <= 1'b0;
            iss_col_q    <= '0;
            col1_q       <= '0;
            col2_q       <= '0;
            score_q      <= '0;
            score_col_q  <= '0;
            for (int k = 0; k < N; k++) begin
                desc_q[k] <= '0;
                prod_q[k] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                row_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            col_cnt_q    <= col_cnt_d;
            desc_ready_q <= desc_ready_d;
            win_ready_q  <= win_ready_d;
            iss_q        <= iss_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            sv_q         <= sv_d;
            iss_col_q    <= iss_col_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
            score_q      <= score_d;
            score_col_q  <= score_col_d;
            desc_q       <= desc_d;
            prod_q       <= prod_d;
            row_q        <= row_d;
            win_q        <= win_d;
        end
    end
endmodule

// File: tb/tb_ncc_corr_array.sv
// tb/tb_ncc_corr_array.sv - self-checking bench for ncc_corr_array
module tb_ncc_corr_array;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int LW = 2;
    localparam int NB = R * C / LW;

    logic clk = 1'b0;
    logic rst, clr, clr_b;
    always #5 clk = ~clk;

    ncc_corr_if #(.ROWS(R), .COLS(C), .PIX_W(8), .LOAD_W(LW)) bs ();
    ncc_corr_if bd ();

    ncc_corr_array #(.ROWS(R), .COLS(C), .PIX_W(8), .LOAD_W(LW)) dut_s (
        .clk(clk), .rst(rst), .clear(clr), .bus(bs)
    );
    ncc_corr_array dut_d (
        .clk(clk), .rst(rst), .clear(clr_b), .bus(bd)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: descriptor, columns of the current line, due scores.
    bit          loaded;
    int          beat;
    byte         desc_m [R*C];
    logic [15:0] line_q [$];
    int          ncol;
    bit          sv_exp [8];
    longint      s_exp  [8];
    int          c_exp  [8];

    typedef struct {
        logic        dv;
        logic [15:0] dd;
        logic        wv;
        logic [15:0] wc;
        logic        wl;
        logic        e_dr;
        logic        e_wr;
        logic        e_sv;
        int          e_score;
        int          e_col;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint corr();
        longint s = 0;
        logic [15:0] colv;
        for (int c = 0; c < C; c++) begin
            colv = line_q[c];
            for (int r = 0; r < R; r++) begin
                s += longint'(desc_m[r*C+c]) * longint'(colv[r*8 +: 8]);
            end
        end
        return s;
    endfunction

    task automatic tick();
        bit          issue = 0;
        bit          kill;
        bit          was_loaded;
        longint      is = 0;
        int          ic = 0;
        int          slot;
        logic [15:0] dd;
        if (cyc > 0) begin
            chk("desc_ready", bs.desc_ready, !loaded);
            chk("win_ready", bs.win_ready, loaded);
        end
        kill       = rst || clr;
        was_loaded = loaded;
        if (!kill) begin
            if (bs.desc_valid && !was_loaded) begin
                dd = bs.desc_data;
                for (int i = 0; i < LW; i++) desc_m[beat*LW+i] = dd[i*8 +: 8];
                beat++;
                if (beat == NB) begin
                    loaded = 1;
                    beat   = 0;
                    line_q.delete();
                    ncol   = 0;
                end
            end
            if (bs.win_valid && was_loaded) begin
                line_q.push_back(bs.win_col);
                if (line_q.size() > C) void'(line_q.pop_front());
                ncol++;
                if (ncol >= C) begin
                    issue = 1;
                    is    = corr();
                    ic    = (ncol - C > 65535) ? 65535 : ncol - C;
                end
                if (bs.win_last) begin
                    line_q.delete();
                    ncol = 0;
                end
            end
        end else begin
            loaded = 0;
            beat   = 0;
            line_q.delete();
            ncol   = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (kill) for (int k = 0; k < 8; k++) sv_exp[k] = 0;
        slot = cyc % 8;
        chk("score_valid", bs.score_valid, sv_exp[slot]);
        if (sv_exp[slot]) begin
            chk("score", bs.score, s_exp[slot]);
            chk("score_col", bs.score_col, c_exp[slot]);
        end
        sv_exp[slot] = 0;
        if (issue) begin
            slot         = (cyc + 3) % 8;
            sv_exp[slot] = 1;
            s_exp[slot]  = is;
            c_exp[slot]  = ic;
        end
    endtask

    task automatic idle_s();
        bs.desc_valid = 0;
        bs.win_valid  = 0;
        bs.win_last   = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n_strobe;
        bit  pat [6] = '{1, 0, 1, 1, 0, 1};

        tbl[0]  = '{1, 16'h0201, 0, 16'h0000, 0, 1, 0, 0, 0,   0};
        tbl[1]  = '{1, 16'h03FF, 0, 16'h0000, 0, 1, 0, 0, 0,   0};
        tbl[2]  = '{1, 16'h0303, 1, 16'h140A, 0, 0, 1, 0, 0,   0};
        tbl[3]  = '{1, 16'h0303, 1, 16'h281E, 0, 0, 1, 0, 0,   0};
        tbl[4]  = '{1, 16'h0303, 1, 16'h3C32, 1, 0, 1, 0, 0,   0};
        tbl[5]  = '{1, 16'h0303, 1, 16'h0101, 0, 0, 1, 0, 0,   0};
        tbl[6]  = '{1, 16'h0303, 1, 16'h0202, 0, 0, 1, 1, 170, 0};
        tbl[7]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 270, 1};
        tbl[8]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 0,   0};
        tbl[9]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 10,  0};
        tbl[10] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 0,   0};

        idle_s();
        bs.desc_data  = '0;
        bs.win_col    = '0;
        bd.desc_valid = 0;
        bd.desc_data  = '0;
        bd.win_valid  = 0;
        bd.win_col    = '0;
        bd.win_last   = 0;
        clr   = 0;
        clr_b = 0;
        loaded = 0;
        beat   = 0;
        ncol   = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        chk("rst_desc_ready", bs.desc_ready, 1);
        chk("rst_win_ready", bs.win_ready, 0);
        chk("rst_score_valid", bs.score_valid, 0);
        chk("rst_score", bs.score, 0);
        chk("rst_score_col", bs.score_col, 0);
        chk("rst_big_desc_ready", bd.desc_ready, 1);
        chk("rst_big_win_ready", bd.win_ready, 0);

        // Directed vectors: load, fill, run, line boundary, held desc_valid.
        for (int i = 0; i < 11; i++) begin
            bs.desc_valid = tbl[i].dv;
            bs.desc_data  = tbl[i].dd;
            bs.win_valid  = tbl[i].wv;
            bs.win_col    = tbl[i].wc;
            bs.win_last   = tbl[i].wl;
            chk($sformatf("tbl%0d_desc_ready", i), bs.desc_ready, tbl[i].e_dr);
            chk($sformatf("tbl%0d_win_ready", i), bs.win_ready, tbl[i].e_wr);
            tick();
            chk($sformatf("tbl%0d_score_valid", i), bs.score_valid, tbl[i].e_sv);
            if (tbl[i].e_sv) begin
                chk($sformatf("tbl%0d_score", i), bs.score, tbl[i].e_score);
                chk($sformatf("tbl%0d_score_col", i), bs.score_col, tbl[i].e_col);
            end
        end

        // Gaps in RUN: strobes follow the valid pattern three cycles later.
        n_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            bs.win_valid = (i < 6) ? pat[i] : 1'b0;
            bs.win_col   = 16'($urandom);
            tick();
            n_strobe += int'(bs.score_valid);
        end
        chk("gap_strobes", n_strobe, 4);

        // clear in the cycle after an issuing column.
        bs.win_valid = 1;
        bs.win_col   = 16'($urandom);
        tick();
        bs.win_valid = 0;
        clr = 1;
        tick();
        clr = 0;
        chk("clr_desc_ready", bs.desc_ready, 1);
        chk("clr_win_ready", bs.win_ready, 0);
        for (int i = 0; i < 4; i++) tick();
        bs.desc_valid = 1;
        bs.desc_data  = 16'($urandom);
        tick();
        bs.desc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            bs.win_valid = 1;
            bs.win_col   = 16'($urandom);
            tick();
        end
        chk("partial_load_win_ready", bs.win_ready, 0);

        // rst mid-RUN.
        bs.win_valid  = 0;
        bs.desc_valid = 1;
        for (int i = 0; i < 2; i++) begin
            bs.desc_data = 16'($urandom);
            tick();
        end
        bs.desc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            bs.win_valid = 1;
            bs.win_col   = 16'($urandom);
            tick();
        end
        bs.win_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_score", bs.score, 0);
        chk("rst_mid_score_col", bs.score_col, 0);
        chk("rst_mid_desc_ready", bs.desc_ready, 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bs.desc_valid = 1'($urandom);
            bs.desc_data  = 16'($urandom);
            bs.win_valid  = ($urandom % 4) != 0;
            bs.win_col    = 16'($urandom);
            bs.win_last   = ($urandom % 8) == 0;
            clr           = ($urandom % 64) == 0;
            tick();
        end
        idle_s();
        clr = 0;
        for (int i = 0; i < 5; i++) tick();

        // Default 16x16 instance: extreme values, no wrap.
        for (int pass = 0; pass < 2; pass++) begin
            bd.desc_data  = (pass == 0) ? {4{8'h80}} : {4{8'h7F}};
            bd.desc_valid = 1;
            for (int i = 0; i < 64; i++) tick();
            bd.desc_valid = 0;
            chk("big_win_ready", bd.win_ready, 1);
            bd.win_col   = '1;
            bd.win_valid = 1;
            for (int i = 0; i < 16; i++) tick();
            bd.win_valid = 0;
            tick();
            tick();
            chk("big_early_valid", bd.score_valid, 0);
            tick();
            chk("big_score_valid", bd.score_valid, 1);
            chk("big_score", bd.score, (pass == 0) ? -64'sd8355840 : 64'sd8290560);
            chk("big_score_col", bd.score_col, 0);
            clr_b = 1;
            tick();
            clr_b = 0;
            tick();
            chk("big_clr_desc_ready", bd.desc_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
